// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The instruction fields and status flags come in; the selects and write enables go out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [2:0] alucontrol;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output immsrc, alusrca, alusrcb, resultsrc, alucontrol,
    output adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  immsrc, alusrca, alusrcb, resultsrc, alucontrol,
    input  adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes and raise illegal.
module multicycle_controller (
  input  logic clk,
  input  logic reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_BEQ:       state <= BEQ;
            OP_JAL:       state <= JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:      state <= TRAP;
`else
            default:      state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (bus.mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (bus.mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  logic       pcupdate, branch, irw, rw, mw;
  logic [1:0] aluop;

  always_comb begin
    pcupdate      = 1'b0;
    branch        = 1'b0;
    irw           = 1'b0;
    rw            = 1'b0;
    mw            = 1'b0;
    aluop         = 2'b00;
    bus.adrsrc    = 1'b0;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.resultsrc = 2'b00;
    case (state)
      FETCH: begin
        irw           = bus.mem_ready;
        pcupdate      = bus.mem_ready;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
      end
      MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      MEMREAD:  bus.adrsrc = 1'b1;
      MEMWB: begin
        bus.resultsrc = 2'b01;
        rw            = 1'b1;
      end
      MEMWRITE: begin
        bus.adrsrc = 1'b1;
        mw         = 1'b1;
      end
      EXECUTER: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b10;
      end
      EXECUTEI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop       = 2'b10;
      end
      ALUWB:    rw = 1'b1;
      BEQ: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b01;
        branch      = 1'b1;
      end
      JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.alucontrol = 3'b000;
    if (aluop == 2'b01) begin
      bus.alucontrol = 3'b001;
    end else if (aluop == 2'b10) begin
      case (bus.funct3)
        3'b000:  bus.alucontrol = {2'b00, bus.op[5] & bus.funct7b5};
        3'b010:  bus.alucontrol = 3'b101;
        3'b110:  bus.alucontrol = 3'b011;
        3'b111:  bus.alucontrol = 3'b010;
        default: bus.alucontrol = 3'b000;
      endcase
    end
  end

  always_comb begin
    bus.immsrc = 2'b00;
    unique case (1'b1)
      bus.op == OP_SW:  bus.immsrc = 2'b01;
      bus.op == OP_BEQ: bus.immsrc = 2'b10;
      bus.op == OP_JAL: bus.immsrc = 2'b11;
      default:          bus.immsrc = 2'b00;
    endcase
  end

  // Reset kills every write enable immediately, even before the edge lands.
  assign bus.irwrite  = reset_n & irw;
  assign bus.pcwrite  = reset_n & (pcupdate | (branch & bus.zero));
  assign bus.regwrite = reset_n & rw;
  assign bus.memwrite = reset_n & mw;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal = (state == TRAP);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction cycle script model.
// Honours CTRL_ILLEGAL_TRAP_EN for the unknown-opcode behaviour.
module tb_multicycle_controller;

  logic clk;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir, pc, rw, mw, adr;
    logic [1:0] a, b, res;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  function automatic vec_t mk(input logic ir, pc, rw, mw, adr,
                              input logic [1:0] a, b, res,
                              input logic [2:0] alu, input logic ill);
    vec_t v;
    v = '{ir, pc, rw, mw, adr, a, b, res, alu, ill};
    return v;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3,
                                         input logic f7, input logic o5);
    if (f3 == 3'd0) return (o5 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'd2) return 3'b101;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input vec_t e, input logic mr, input logic z);
    vec_t g;
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    g = {bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.adrsrc,
         bus.alusrca, bus.alusrcb, bus.resultsrc, bus.alucontrol,
         bus.illegal};
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL ctl op=%b got=%h exp=%h", bus.op, g, e);
    end
    tests++;
    assert (bus.immsrc === ref_imm(bus.op)) else begin
      fails++;
      $error("FAIL immsrc op=%b got=%b exp=%b", bus.op, bus.immsrc,
             ref_imm(bus.op));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst(input int n);
    reset_n = 1'b0;
    repeat (n) begin
      bus.mem_ready = rb();
      bus.zero      = rb();
      @(negedge clk);
      tests++;
      assert ({bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite}
              === 4'b0000) else begin
        fails++;
        $error("FAIL rst_en got=%b exp=0000", {bus.irwrite, bus.pcwrite,
               bus.regwrite, bus.memwrite});
      end
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  vec_t v_memrd, v_memwb, v_memwr, v_aluwb, v_jal, v_dec, v_madr, v_trap;

  task automatic fetch_phase();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,0), 1'b0, rb());
    cyc(mk(1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,0), 1'b1, rb());
  endtask

  task automatic exec(input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input int w);
    logic [2:0] a;
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    a = ref_alu(f3, f7, o[5]);
    fetch_phase();
    cyc(v_dec, rb(), rb());
    case (o)
      7'b0000011: begin
        cyc(v_madr, rb(), rb());
        repeat (w) cyc(v_memrd, 1'b0, rb());
        cyc(v_memrd, 1'b1, rb());
        cyc(v_memwb, rb(), rb());
      end
      7'b0100011: begin
        cyc(v_madr, rb(), rb());
        repeat (w) cyc(v_memwr, 1'b0, rb());
        cyc(v_memwr, 1'b1, rb());
      end
      7'b0110011: begin
        cyc(mk(0,0,0,0,0,2'b10,2'b00,2'b00,a,0), rb(), rb());
        cyc(v_aluwb, rb(), rb());
      end
      7'b0010011: begin
        cyc(mk(0,0,0,0,0,2'b10,2'b01,2'b00,a,0), rb(), rb());
        cyc(v_aluwb, rb(), rb());
      end
      7'b1100011: cyc(mk(0,z,0,0,0,2'b10,2'b00,2'b00,3'b001,0), rb(), z);
      7'b1101111: begin
        cyc(v_jal, rb(), rb());
        cyc(v_aluwb, rb(), rb());
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        repeat (3) cyc(v_trap, rb(), rb());
        rst(1);
`endif
      end
    endcase
  endtask

  logic [6:0] ops [0:6];
  logic [6:0] bad [0:2];

  initial begin
    v_dec   = mk(0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,0);
    v_madr  = mk(0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,0);
    v_memrd = mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0);
    v_memwb = mk(0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0);
    v_memwr = mk(0,0,0,1,1,2'b00,2'b00,2'b00,3'b000,0);
    v_aluwb = mk(0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,0);
    v_jal   = mk(0,1,0,0,0,2'b01,2'b10,2'b00,3'b000,0);
    v_trap  = mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1);
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0000000};
    bad = '{7'b0000000, 7'b1110011, 7'b0110111};

    reset_n       = 1'b0;
    bus.op        = 7'b0000000;
    bus.funct3    = 3'b000;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst(2);

    exec(7'b0000011, 3'b010, 1'b0, 1'b0, 2);
    exec(7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    exec(7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    exec(7'b0110011, 3'b000, 1'b0, 1'b0, 0);
    exec(7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    exec(7'b0010011, 3'b010, 1'b0, 1'b0, 0);
    exec(7'b0110011, 3'b110, 1'b0, 1'b0, 0);
    exec(7'b0110011, 3'b111, 1'b1, 1'b0, 0);
    exec(7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    exec(7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    exec(7'b1101111, 3'b000, 1'b0, 1'b0, 0);

    // Abandon a store while it is waiting in MEMWRITE.
    bus.op = 7'b0100011;
    cyc(mk(1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,0), 1'b1, rb());
    cyc(v_dec, rb(), rb());
    cyc(v_madr, rb(), rb());
    rst(1);

    for (int i = 0; i < 60; i++) begin
      int k;
      logic [6:0] o;
`ifdef CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 6);
`endif
      o = (k == 6) ? bad[$urandom_range(0, 2)] : ops[k];
      exec(o, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 3));
    end

    exec(7'b0000000, 3'b000, 1'b0, 1'b0, 0);
    exec(7'b0000011, 3'b000, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
